// File: rtl/muldiv_controller_if.sv
// Execute-side request/response handshake and the shared multiplier/divider unit
// handshake seen by muldiv_controller, bundled into one interface.
interface muldiv_controller_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        stall;
    logic        timeout_err;
    logic        Run;
    logic        div;
    logic [32:0] opA;
    logic [32:0] opB;
    logic [32:0] Aval;
    logic [32:0] Bval;
    logic        ready;
    logic        X;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, flush, Aval, Bval, ready, X,
        input  req_ready, resp_valid, resp_data, stall, timeout_err, Run, div, opA, opB
    );

    // X is a spare unit output that the controller never looks at.
    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, flush, Aval, Bval, ready,
        output req_ready, resp_valid, resp_data, stall, timeout_err, Run, div, opA, opB
    );
endinterface

// File: rtl/muldiv_controller.sv
// Sequences RV32M ops onto the shared 33-bit multiply/divide unit: operand extension,
// early divide results, start/wait/result handshake, flush draining and a wait watchdog.
module muldiv_controller #(
    parameter int unsigned WAIT_LIMIT = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    muldiv_controller_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e           state_q;
    logic [2:0]       f3_q;
    logic [32:0]      opa_q;
    logic [32:0]      opb_q;
    logic             div_q;
    logic             run_q;
    logic             stall_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic [31:0]      res_q;
    logic [31:0]      out_q;
    logic             timeout_q;
    logic [CNT_W-1:0] wd_cnt_q;

    logic [32:0]      opa_d;
    logic [32:0]      opb_d;
    logic [31:0]      special_res_d;
    logic [31:0]      unit_res_d;
    logic             div_zero_s;
    logic             ovf_s;
    logic             special_s;
    logic             accept_s;
    logic             wd_expire_s;
    logic             resp_fire_s;

    function automatic logic sign_ext_a(input logic [2:0] f3);
        logic s;
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b110: s = 1'b1;
            default:                                s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic sign_ext_b(input logic [2:0] f3);
        logic s;
        case (f3)
            3'b000, 3'b001, 3'b100, 3'b110: s = 1'b1;
            default:                        s = 1'b0;
        endcase
        return s;
    endfunction

    // High-half products live across the Aval/Bval boundary of the 66-bit result.
    function automatic logic [31:0] select_result(input logic [2:0] f3,
                                                  input logic [32:0] a,
                                                  input logic [32:0] b);
        logic [31:0] r;
        case (f3)
            3'b000, 3'b100, 3'b101: r = b[31:0];
            3'b001, 3'b010, 3'b011: r = {a[30:0], b[32]};
            3'b110, 3'b111:         r = a[31:0];
            default:                r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Operand extension and early-result detection for the request on offer.
    always_comb begin
        opa_d      = {sign_ext_a(bus.req_funct3) & bus.req_rs1[31], bus.req_rs1};
        opb_d      = {sign_ext_b(bus.req_funct3) & bus.req_rs2[31], bus.req_rs2};
        div_zero_s = bus.req_funct3[2] && (bus.req_rs2 == 32'h0000_0000);
        ovf_s      = bus.req_funct3[2] && !bus.req_funct3[0] &&
                     (bus.req_rs1 == 32'h8000_0000) && (bus.req_rs2 == 32'hFFFF_FFFF);
        special_s  = div_zero_s || ovf_s;
        if (div_zero_s) begin
            special_res_d = bus.req_funct3[1] ? bus.req_rs1 : 32'hFFFF_FFFF;
        end else if (ovf_s) begin
            special_res_d = bus.req_funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
        end else begin
            special_res_d = 32'h0000_0000;
        end
        unit_res_d  = select_result(f3_q, bus.Aval, bus.Bval);
        accept_s    = (state_q == S_IDLE) && bus.req_valid && !bus.flush;
        wd_expire_s = (wd_cnt_q == CNT_LAST);
    end

    // A flush landing in DONE cancels the response, so resp_data keeps the last delivered value.
    assign resp_fire_s     = resp_valid_q && !bus.flush;
    assign bus.resp_valid  = resp_fire_s;
    assign bus.resp_data   = resp_fire_s ? res_q : out_q;
    assign bus.req_ready   = req_ready_q;
    assign bus.stall       = stall_q;
    assign bus.Run         = run_q;
    assign bus.div         = div_q;
    assign bus.opA         = opa_q;
    assign bus.opB         = opb_q;
    assign bus.timeout_err = timeout_q;

    // Controller FSM with registered handshake outputs and wait watchdog.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            f3_q         <= 3'b000;
            opa_q        <= 33'h0_0000_0000;
            opb_q        <= 33'h0_0000_0000;
            div_q        <= 1'b0;
            run_q        <= 1'b0;
            stall_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            res_q        <= 32'h0000_0000;
            out_q        <= 32'h0000_0000;
            timeout_q    <= 1'b0;
            wd_cnt_q     <= '0;
        end else begin
            run_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        f3_q        <= bus.req_funct3;
                        opa_q       <= opa_d;
                        opb_q       <= opb_d;
                        div_q       <= bus.req_funct3[2];
                        req_ready_q <= 1'b0;
                        stall_q     <= 1'b1;
                        wd_cnt_q    <= '0;
                        if (special_s) begin
                            state_q      <= S_DONE;
                            res_q        <= special_res_d;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            run_q   <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (bus.flush) begin
                        state_q <= S_DRAIN;
                        stall_q <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.ready) begin
                        if (bus.flush) begin
                            state_q     <= S_IDLE;
                            stall_q     <= 1'b0;
                            req_ready_q <= 1'b1;
                        end else begin
                            state_q      <= S_DONE;
                            res_q        <= unit_res_d;
                            resp_valid_q <= 1'b1;
                        end
                    end else if (wd_expire_s) begin
                        timeout_q <= 1'b1;
                        if (bus.flush) begin
                            state_q     <= S_IDLE;
                            stall_q     <= 1'b0;
                            req_ready_q <= 1'b1;
                        end else begin
                            state_q      <= S_DONE;
                            res_q        <= 32'h0000_0000;
                            resp_valid_q <= 1'b1;
                        end
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
                        if (bus.flush) begin
                            state_q <= S_DRAIN;
                            stall_q <= 1'b0;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    stall_q     <= 1'b0;
                    req_ready_q <= 1'b1;
                    if (!bus.flush) begin
                        out_q <= res_q;
                    end else begin
                        out_q <= out_q;
                    end
                end
                S_DRAIN: begin
                    if (bus.ready || wd_expire_s) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        timeout_q   <= timeout_q | (wd_expire_s & ~bus.ready);
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    stall_q     <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/muldiv_controller.md
# muldiv_controller

Sequencing controller for the shared 33-bit `Multiplier` unit in the RV32I execute stage, providing the RV32M instructions MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Accepts one M-extension op at a time from execute.
- Sign- or zero-extends operands to 33 bits, pulses `Run`/`div` into the unit, waits for `ready`, and selects and registers the 32-bit result.
- Resolves divide-by-zero and signed overflow itself, without starting the unit.
- Holds a stall toward the pipeline while busy and safely drains the unit on a pipeline flush.

## Interface
- `WAIT_LIMIT`, default 64: cycles allowed from `Run` pulse to `ready` before the watchdog fires.
- `Clk`  in  1  system clock; all logic is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute presents an M-op this cycle.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_funct3`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `req_rs1`, `req_rs2`  in  32  operands.
- `flush`  in  1  kills the in-flight op; no response is produced for it.
- `resp_valid`  out  1  one-cycle pulse; `resp_data` is valid.
- `resp_data`  out  32  result.
- `stall`  out  1  holds the pipeline; high in every non-IDLE state except DRAIN.
- `timeout_err`  out  1  sticky; set by the watchdog, cleared only by `Reset`.
- `Run`  out  1  one-cycle start pulse to the unit.
- `div`  out  1  0 = multiply, 1 = divide; held stable from `Run` until `ready`.
- `opA`, `opB`  out  33  extended operands; held stable from `Run` until `ready`.
- `Aval`, `Bval`  in  33  unit results. For multiply, {`Aval`,`Bval`} is the 66-bit signed product. For divide, `Bval` is the quotient and `Aval` is the remainder.
- `ready`  in  1  one-cycle done pulse from the unit.
- `X`  in  1  unused.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- **IDLE**, on `req_valid`:
  - Latch `req_funct3` and the operands.
  - Compute extended operands.
    - `opA` is sign-extended for MUL, MULH, MULHSU, DIV and REM; otherwise zero-extended.
    - `opB` is sign-extended for MUL, MULH, DIV and REM; otherwise zero-extended.
  - Special cases go directly to DONE with the result preloaded:
    - Divide by zero (rs2 == 0): DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
    - Signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
  - All other ops go to ISSUE.
- **ISSUE**: `Run` = 1 for exactly this cycle, `div` = funct3[2]; go to WAIT.
- **WAIT**: hold `opA`, `opB` and `div`. The watchdog counter increments each cycle.
  - On `ready`, register the result and go to DONE. Result selection:
    - MUL: `Bval`[31:0].
    - MULH, MULHSU, MULHU: product bits [63:32], i.e. {`Aval`[30:0],`Bval`[32]}.
    - DIV, DIVU: `Bval`[31:0].
    - REM, REMU: `Aval`[31:0].
  - If the counter reaches `WAIT_LIMIT` with no `ready`: set `timeout_err`, go to DONE, and return result 0.
- **DONE**: `resp_valid` = 1 for one cycle; go to IDLE.
- **Flush**:
  - In ISSUE: `Run` is still pulsed, then go to DRAIN.
  - In WAIT: go to DRAIN.
  - In DONE: suppress `resp_valid` and go to IDLE.
- **DRAIN**: wait for `ready` (or the watchdog), discard the result, go to IDLE.
  - `stall` = 0 and `req_ready` = 0, so the pipeline may refill behind the drain.
- `flush` in IDLE has no effect. `flush` and `req_valid` in the same IDLE cycle: the request is not accepted.
- Reset in any state, mid-operation included: return to IDLE next edge; the unit's pending `ready` is ignored after reset.

## Timing
- Reset values:
  - `req_ready` = 1.
  - `stall`, `resp_valid`, `Run`, `div`, `timeout_err` = 0.
  - `resp_data`, `opA`, `opB` = 0.
  - Watchdog counter = 0.
  - State = IDLE.
- Normal op:
  - Accepted at cycle T; `Run` high at T+1.
  - The unit returns `ready` at T+1+L.
  - `resp_valid` is high at T+2+L.
  - `stall` is high from T+1 through T+2+L inclusive.
- Special case: accepted at T, `resp_valid` at T+1, `Run` never asserted.
- Back-to-back: the next request can be accepted in the cycle after `resp_valid` at the earliest.
- `resp_data` holds its value until the next `resp_valid`.
- `ready` seen outside WAIT and DRAIN is ignored.

## Test plan
- MUL 7 × −3 (rs1 = 7, rs2 = 0xFFFFFFFD) -> `opA` = 0x000000007, `opB` = 0x1FFFFFFFD, `Run` one cycle, `resp_data` = 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> `resp_data` = 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU with the same operands -> 0xFFFFFFFF.
- DIV 0 / 500, then DIVU 500 / 0 and REM 500 / 0 -> DIV returns 0. DIVU returns 0xFFFFFFFF and REM returns 500, each with `resp_valid` at T+1 and no `Run`.
- DIV 0x80000000 / −1 -> `resp_data` = 0x80000000. REM with the same operands -> 0. `Run` is never pulsed for either.
- DIV 100 / 7, then `flush` two cycles after `Run` -> `stall` drops and `req_ready` stays 0 until `ready`, no `resp_valid`. A following REMU 100 / 7 returns 2.
- Unit model never asserts `ready` -> `timeout_err` = 1 after 64 WAIT cycles and `resp_valid` with 0. `Reset` pulsed mid-WAIT on a second op -> IDLE with all outputs at reset values.
